// File: rtl/flopoco_to_ieee_fp64_pkg.sv
// ============================================================================
// Module : flopoco_to_ieee_fp64_pkg
// Brief  : FloPoCo exception encodings and IEEE-754 binary64 constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package flopoco_to_ieee_fp64_pkg;

  localparam logic [1:0]  EXN_ZERO   = 2'b00;
  localparam logic [1:0]  EXN_NORMAL = 2'b01;
  localparam logic [1:0]  EXN_INF    = 2'b10;
  localparam logic [1:0]  EXN_NAN    = 2'b11;

  localparam logic [63:0] QNAN_FP64  = 64'h7FF8_0000_0000_0000;

endpackage

`default_nettype wire

// File: rtl/flopoco_to_ieee_fp64.sv
// ============================================================================
// Module : flopoco_to_ieee_fp64
// Brief  : Single-stage FloPoCo to IEEE-754 converter with valid strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module flopoco_to_ieee_fp64
  import flopoco_to_ieee_fp64_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 52
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_in,
  input  logic [WE+WF+2:0] flopoco_in,
  output logic             push_out,
  output logic [WE+WF:0]   ieee_out
);

  localparam logic [WE-1:0] c_exp_ones = {WE{1'b1}};
  localparam logic [WE-1:0] c_exp_zero = {WE{1'b0}};
  localparam logic [WF-1:0] c_frac_zero = {WF{1'b0}};
  localparam logic [WE+WF:0] c_qnan = {1'b0, {WE{1'b1}}, 1'b1, {(WF-1){1'b0}}};

  logic [1:0]      w_exn;
  logic            w_sign;
  logic [WE-1:0]   w_exp;
  logic [WF-1:0]   w_frac;
  logic [WE+WF:0]  w_decoded;

  logic            push_d, push_q;
  logic [WE+WF:0]  ieee_d, ieee_q;

  assign w_exn  = flopoco_in[WE+WF+2:WE+WF+1];
  assign w_sign = flopoco_in[WE+WF];
  assign w_exp  = flopoco_in[WE+WF-1:WF];
  assign w_frac = flopoco_in[WF-1:0];

  // Exponent extremes inside a "normal" word have no IEEE normal encoding:
  // zero flushes to signed zero, all-ones saturates to signed infinity.
  always_comb begin
    w_decoded = {w_sign, c_exp_zero, c_frac_zero};
    case (w_exn)
      EXN_ZERO:   w_decoded = {w_sign, c_exp_zero, c_frac_zero};
      EXN_NORMAL: begin
        if (w_exp == c_exp_zero)
          w_decoded = {w_sign, c_exp_zero, c_frac_zero};
        else if (w_exp == c_exp_ones)
          w_decoded = {w_sign, c_exp_ones, c_frac_zero};
        else
          w_decoded = {w_sign, w_exp, w_frac};
      end
      EXN_INF:    w_decoded = {w_sign, c_exp_ones, c_frac_zero};
      default:    w_decoded = c_qnan;
    endcase
  end

  // Holding on idle cycles keeps undriven input bits out of the output.
  always_comb begin
    push_d = push_in;
    ieee_d = push_in ? w_decoded : ieee_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q <= 1'b0;
      ieee_q <= '0;
    end else begin
      push_q <= push_d;
      ieee_q <= ieee_d;
    end
  end

  assign push_out = push_q;
  assign ieee_out = ieee_q;

endmodule

`default_nettype wire

// File: tb/tb_flopoco_to_ieee_fp64.sv
// ============================================================================
// Module : tb_flopoco_to_ieee_fp64
// Brief  : Directed vector bench for the FloPoCo to IEEE-754 converter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_flopoco_to_ieee_fp64;

  typedef struct {
    logic [1:0]  exn;
    logic        s;
    logic [10:0] e;
    logic [51:0] f;
    logic [63:0] expected;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_in = 1'b0;
  logic [65:0] flopoco_in = '0;
  logic        push_out;
  logic [63:0] ieee_out;

  int checks = 0;
  int errors = 0;

  vec_t vecs [12];

  flopoco_to_ieee_fp64 #(.WE(11), .WF(52)) dut (
    .clk        (clk),
    .rst        (rst),
    .push_in    (push_in),
    .flopoco_in (flopoco_in),
    .push_out   (push_out),
    .ieee_out   (ieee_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Drive one push at the falling edge, check it just after the next rising edge.
  task automatic push_word(input logic [65:0] word, input logic [63:0] req, input string name);
    @(negedge clk);
    push_in    = 1'b1;
    flopoco_in = word;
    @(posedge clk);
    #1;
    check1({name, ".push"}, push_out, 1'b1);
    check64({name, ".data"}, ieee_out, req);
  endtask

  task automatic idle();
    @(negedge clk);
    push_in    = 1'b0;
    flopoco_in = '0;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 1'b1, 11'h123, 52'hABC,             64'h8000_0000_0000_0000};
    vecs[1]  = '{2'b00, 1'b0, 11'h123, 52'hABC,             64'h0000_0000_0000_0000};
    vecs[2]  = '{2'b10, 1'b1, 11'h5A5, 52'h12345,           64'hFFF0_0000_0000_0000};
    vecs[3]  = '{2'b11, 1'b1, 11'h7FF, 52'h5,               64'h7FF8_0000_0000_0000};
    vecs[4]  = '{2'b01, 1'b0, 11'h000, 52'h1,               64'h0000_0000_0000_0000};
    vecs[5]  = '{2'b01, 1'b1, 11'h7FF, 52'h1,               64'hFFF0_0000_0000_0000};
    vecs[6]  = '{2'b01, 1'b1, 11'h400, 52'h8_0000_0000_0000, 64'hC008_0000_0000_0000};
    vecs[7]  = '{2'b01, 1'b0, 11'h7FE, 52'hF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF};
    vecs[8]  = '{2'b01, 1'b1, 11'h001, 52'h0,               64'h8010_0000_0000_0000};
    vecs[9]  = '{2'b11, 1'b0, 11'h000, 52'h0,               64'h7FF8_0000_0000_0000};
    vecs[10] = '{2'b10, 1'b0, 11'h000, 52'h0,               64'h7FF0_0000_0000_0000};
    vecs[11] = '{2'b01, 1'b1, 11'h000, 52'hFFFFF,           64'h8000_0000_0000_0000};

    // Reset state
    #1;
    check1("reset.push", push_out, 1'b0);
    check64("reset.data", ieee_out, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1.0 then idle: output must hold
    push_word({2'b01, 1'b0, 11'h3FF, 52'h0}, 64'h3FF0_0000_0000_0000, "one");
    idle();
    @(posedge clk);
    #1;
    check1("hold.push", push_out, 1'b0);
    check64("hold.data", ieee_out, 64'h3FF0_0000_0000_0000);

    // Table of exception and edge-exponent cases
    for (int i = 0; i < 12; i++) begin
      push_word({vecs[i].exn, vecs[i].s, vecs[i].e, vecs[i].f}, vecs[i].expected,
                $sformatf("vec%0d", i));
      idle();
    end

    // Streaming 1.0 .. 25.0 back to back
    @(posedge clk);
    #1;
    check1("stream.pre", push_out, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      logic [63:0] bits;
      bits = $realtobits(real'(k));
      push_word({2'b01, bits}, bits, $sformatf("stream%0d", k));
    end
    idle();
    @(posedge clk);
    #1;
    check1("stream.post", push_out, 1'b0);

    // Reset asserted between edges while push_out is high
    push_word({2'b01, 1'b0, 11'h400, 52'h0}, 64'h4000_0000_0000_0000, "prerst");
    #2;
    rst = 1'b0;
    #1;
    check1("rstasync.push", push_out, 1'b0);
    check64("rstasync.data", ieee_out, 64'h0);
    @(posedge clk);
    #1;
    check1("rsthold.push", push_out, 1'b0);
    check64("rsthold.data", ieee_out, 64'h0);
    @(negedge clk);
    push_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check1("postrst.idle", push_out, 1'b0);
    push_word({2'b01, 1'b1, 11'h3FF, 52'h0}, 64'hBFF0_0000_0000_0000, "postrst");
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flopoco_to_ieee_fp64.md
Name: flopoco_to_ieee_fp64

Overview:
- Converts one FloPoCo-format floating-point word into an IEEE-754 binary64 word, with a valid strobe.
- Sits after the FloPoCo multiplier and adder inside the sparse-MV multiply-accumulate datapath.
- Also serves as a debug/observation converter, so that FloPoCo intermediates can be printed as reals.
- Single registered stage; no back-pressure.

Parameters:
- WE, 11, exponent width in bits (IEEE double).
- WF, 52, fraction width in bits (IEEE double).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- push_in  input  1  input word valid this cycle.
- flopoco_in  input  WE+WF+3 (66)  FloPoCo word: [65:64] exception, [63] sign, [62:52] biased exponent, [51:0] fraction.
- push_out  output  1  ieee_out valid this cycle.
- ieee_out  output  WE+WF+1 (64)  IEEE-754 word: [63] sign, [62:52] exponent, [51:0] fraction.

Behaviour:
- Reset (rst=0, asynchronous): push_out=0 and ieee_out=0 immediately, and held while rst=0. Any in-flight word is discarded.
- Latency is exactly 1 clock.
  - push_out at edge N+1 equals push_in sampled at edge N.
  - Back-to-back pushes produce back-to-back outputs, one per cycle, with no bubbles.
- The ieee_out register loads only when push_in=1 and holds its previous value otherwise. Two instances fed the same push therefore stay aligned.
- Exception field mapping (s = input sign, e = input exponent, f = input fraction):
  - 00 zero: output {s, 0 exponent, 0 fraction}. Input exponent/fraction are don't-care and ignored. Signed zero is preserved.
  - 01 normal, 0 < e < 2^WE-1: output {s, e, f} bit-exact. Both formats use the same bias 2^(WE-1)-1 = 1023.
  - 01 normal, e == 0: flush to signed zero {s, 0, 0}. The IEEE subnormal range is not produced.
  - 01 normal, e == all-ones: overflow to signed infinity {s, all-ones, 0}.
  - 10 infinity: {s, all-ones exponent, 0 fraction}.
  - 11 NaN: canonical quiet NaN 0x7FF8000000000000 (sign 0, fraction MSB 1, rest 0), regardless of s/e/f.
- Purely combinational decode into one output register; no internal state beyond the push_out and ieee_out flops.
- No flow control: the consumer must accept every push_out pulse.
- X on flopoco_in when push_in=0 must not propagate to ieee_out.

Decomposition:
- Shared package: localparams EXN_ZERO=2'b00, EXN_NORMAL=2'b01, EXN_INF=2'b10, EXN_NAN=2'b11, and the canonical quiet-NaN constant.
- The package is also used by the FloPoCo multiplier/adder wrappers and the matching ieee_to_flopoco converter.
- No sub-module; single flat module.

Test Plan:
1. Normal value.
   - Stimulus: push_in=1 with flopoco_in={01,0,0x3FF,0} (1.0), then push_in=0.
   - Response: next cycle push_out=1, ieee_out=0x3FF0000000000000; following cycle push_out=0 and ieee_out holds 0x3FF0000000000000.
2. Signed zero.
   - Stimulus: flopoco_in={00,1,0x123,0xABC} pushed.
   - Response: ieee_out=0x8000000000000000. A same-word push with sign 0 gives 0x0000000000000000.
3. Infinity and NaN.
   - Stimulus: push {10,1,x,x}, then {11,1,0x7FF,5}.
   - Response: ieee_out=0xFFF0000000000000, then 0x7FF8000000000000.
4. Edge exponents.
   - Stimulus: push {01,0,0x000,0x1}, then {01,1,0x7FF,0x1}.
   - Response: 0x0000000000000000 (flush to zero), then 0xFFF0000000000000 (overflow to infinity).
5. Streaming.
   - Stimulus: 25 consecutive pushes of normals 1.0, 2.0, ..., 25.0.
   - Response: 25 consecutive push_out cycles, each delayed exactly one clock; values match $realtobits(k) in order.
6. Reset mid-stream.
   - Stimulus: drop rst to 0 between clock edges while push_out=1.
   - Response: push_out and ieee_out go to 0 immediately (before the next edge) and stay 0 until rst=1.
   - The first push after rst returns to 1 appears one cycle later.
